// File: rtl/instr_encoder_loader_if.sv
// Request and instruction-memory write bus for the encoder/loader.
// slave = the loader, master = whoever issues requests and owns the memory.
interface instr_encoder_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        imem_ready;

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output in_ready,
    output imem_we, imem_addr, imem_wdata,
    input  imem_ready
  );

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  in_ready,
    input  imem_we, imem_addr, imem_wdata,
    output imem_ready
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs RV32I fields + decoded immediate back into an instruction word,
// buffers words in a small FIFO and streams them to instruction memory
// at sequential (wrapping) word addresses.
module instr_encoder_loader #(
  parameter int          DEPTH     = 4,
  parameter int          IMEM_AW   = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  instr_encoder_loader_if.slave bus,
  output logic [IMEM_AW:0]      count,
  output logic                  busy,
  output logic                  err_range,
  output logic                  err_fmt
);
  localparam int          PW       = $clog2(DEPTH);
  localparam logic [PW:0] FULL_OCC = (PW+1)'(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;
  state_t r_state, w_state_nxt;

  logic [31:0]        r_mem [DEPTH];
  logic [PW-1:0]      r_wp, r_rp;
  logic [PW:0]        r_occ;
  logic [IMEM_AW-1:0] r_idx;
  logic [IMEM_AW:0]   r_count;
  logic               r_err_range, r_err_fmt;

  logic        w_full, w_empty, w_push, w_pop, w_start;
  logic [31:0] w_imm, w_word;
  logic        w_bad_rng, w_bad_fmt;
  logic        w_sx12, w_sx13, w_sx21;

  assign w_imm   = bus.in_imm;
  assign w_full  = (r_occ == FULL_OCC);
  assign w_empty = (r_occ == '0);
  // start only matters when idle; it still blocks accept in any state
  assign w_start = start && (r_state == IDLE);
  assign w_push  = bus.in_valid && bus.in_ready;
  assign w_pop   = !w_empty && bus.imem_ready;

  // immediate fits when all bits above the field's sign bit copy it
  assign w_sx12 = (&w_imm[31:11]) | ~(|w_imm[31:11]);
  assign w_sx13 = (&w_imm[31:12]) | ~(|w_imm[31:12]);
  assign w_sx21 = (&w_imm[31:20]) | ~(|w_imm[31:20]);

  // field packing and range/format validation for the incoming request
  always_comb begin
    w_word    = 32'h0000_0013;
    w_bad_rng = 1'b0;
    w_bad_fmt = 1'b0;
    case (bus.in_fmt)
      3'd0: w_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
      3'd1: begin
        w_word    = {w_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
        w_bad_rng = !w_sx12;
      end
      3'd2: begin
        w_word    = {w_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, w_imm[4:0], bus.in_opcode};
        w_bad_rng = !w_sx12;
      end
      3'd3: begin
        w_word    = {w_imm[12], w_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                     w_imm[4:1], w_imm[11], bus.in_opcode};
        w_bad_rng = w_imm[0] || !w_sx13;
      end
      3'd4: begin
        w_word    = {w_imm[31:12], bus.in_rd, bus.in_opcode};
        w_bad_rng = (w_imm[11:0] != 12'h0);
      end
      3'd5: begin
        w_word    = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], bus.in_rd, bus.in_opcode};
        w_bad_rng = w_imm[0] || !w_sx21;
      end
      default: w_bad_fmt = 1'b1;
    endcase
  end

  // FIFO storage (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= w_word;
  end

  // FIFO pointers, write address/count and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_occ       <= '0;
      r_idx       <= '0;
      r_count     <= '0;
      r_err_range <= 1'b0;
      r_err_fmt   <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
      if (w_start) begin
        r_idx       <= '0;
        r_count     <= '0;
        r_err_range <= 1'b0;
        r_err_fmt   <= 1'b0;
      end else begin
        if (w_pop) begin
          r_idx <= r_idx + 1'b1;
          if (!r_count[IMEM_AW]) r_count <= r_count + 1'b1;
        end
        if (w_push && w_bad_rng) r_err_range <= 1'b1;
        if (w_push && w_bad_fmt) r_err_fmt   <= 1'b1;
      end
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // IDLE <-> RUN tracks whether the FIFO holds anything
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_push) w_state_nxt = RUN;
      RUN:  if (w_pop && (r_occ == (PW+1)'(1)) && !w_push) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready   = !w_full && !start;
  assign bus.imem_we    = !w_empty;
  assign bus.imem_wdata = w_empty ? 32'h0 : r_mem[r_rp];
  assign bus.imem_addr  = BASE_ADDR + {{(30-IMEM_AW){1'b0}}, r_idx, 2'b00};
  assign count          = r_count;
  assign busy           = (r_state == RUN);
  assign err_range      = r_err_range;
  assign err_fmt        = r_err_fmt;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: two instances (IMEM_AW=10 and 2) share
// stimulus; a queue model is compared every cycle, plus literal pins.
module tb_instr_encoder_loader;
  localparam int DEPTH = 4;
  localparam int AWA   = 10;
  localparam int AWB   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic imem_ready = 1'b0;
  logic [2:0]  fmt = '0;
  logic [6:0]  op = '0;
  logic [6:0]  f7 = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  f3 = '0;
  logic [31:0] imm = '0;

  logic [AWA:0] count_a;
  logic [AWB:0] count_b;
  logic busy_a, busy_b, er_a, er_b, ef_a, ef_b;

  int checks = 0;
  int failures = 0;

  logic [31:0] mq[$];
  int  m_written = 0;
  bit  m_er = 0, m_ef = 0;
  logic [31:0] loga[$];
  logic [31:0] logb[$];

  always #5 clk = ~clk;

  instr_encoder_loader_if ifa ();
  instr_encoder_loader_if ifb ();

  assign ifa.in_valid = in_valid;   assign ifb.in_valid = in_valid;
  assign ifa.in_fmt = fmt;          assign ifb.in_fmt = fmt;
  assign ifa.in_opcode = op;        assign ifb.in_opcode = op;
  assign ifa.in_rd = rd;            assign ifb.in_rd = rd;
  assign ifa.in_rs1 = rs1;          assign ifb.in_rs1 = rs1;
  assign ifa.in_rs2 = rs2;          assign ifb.in_rs2 = rs2;
  assign ifa.in_funct3 = f3;        assign ifb.in_funct3 = f3;
  assign ifa.in_funct7 = f7;        assign ifb.in_funct7 = f7;
  assign ifa.in_imm = imm;          assign ifb.in_imm = imm;
  assign ifa.imem_ready = imem_ready;
  assign ifb.imem_ready = imem_ready;

  instr_encoder_loader #(.DEPTH(DEPTH), .IMEM_AW(AWA), .BASE_ADDR(32'h0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(ifa.slave),
    .count(count_a), .busy(busy_a), .err_range(er_a), .err_fmt(ef_a));

  instr_encoder_loader #(.DEPTH(DEPTH), .IMEM_AW(AWB), .BASE_ADDR(32'h0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(ifb.slave),
    .count(count_b), .busy(busy_b), .err_range(er_b), .err_fmt(ef_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference encoding, written straight from the instruction layouts
  function automatic logic [31:0] m_enc(input logic [2:0] f, input logic [6:0] o, input logic [4:0] d,
                                        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] fn3,
                                        input logic [6:0] fn7, input logic [31:0] im);
    case (f)
      3'd0: return {fn7, s2, s1, fn3, d, o};
      3'd1: return {im[11:0], s1, fn3, d, o};
      3'd2: return {im[11:5], s2, s1, fn3, im[4:0], o};
      3'd3: return {im[12], im[10:5], s2, s1, fn3, im[4:1], im[11], o};
      3'd4: return {im[31:12], d, o};
      3'd5: return {im[20], im[10:1], im[11], im[19:12], d, o};
      default: return 32'h0000_0013;
    endcase
  endfunction

  // representability as signed integer ranges
  function automatic bit m_bad(input logic [2:0] f, input logic [31:0] im);
    longint v;
    v = longint'($signed(im));
    case (f)
      3'd1, 3'd2: return (v < -2048) || (v > 2047);
      3'd3:       return im[0] || (v < -4096) || (v > 4095);
      3'd4:       return im[11:0] != 12'h0;
      3'd5:       return im[0] || (v < -(64'sd1 <<< 20)) || (v > (64'sd1 <<< 20) - 1);
      default:    return 1'b0;
    endcase
  endfunction

  // core immediate generator, used to pin round-trip values
  function automatic logic [31:0] imm_gen(input logic [31:0] w);
    case (w[6:0])
      7'h63:        return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
      7'h23:        return {{21{w[31]}}, w[30:25], w[11:7]};
      7'h37, 7'h17: return {w[31:12], 12'h0};
      7'h6F:        return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
      default:      return {{21{w[31]}}, w[30:20]};
    endcase
  endfunction

  // model: queue of words, count of completed writes, sticky flags
  initial forever begin
    bit acc, pop, st;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete(); m_written = 0; m_er = 0; m_ef = 0;
    end else begin
      st  = start && (mq.size() == 0);
      acc = in_valid && (mq.size() < DEPTH) && !start;
      pop = (mq.size() > 0) && imem_ready;
      if (pop) begin void'(mq.pop_front()); m_written++; end
      if (acc) begin
        mq.push_back(m_enc(fmt, op, rd, rs1, rs2, f3, f7, imm));
        if (fmt > 3'd5) m_ef = 1;
        else if (m_bad(fmt, imm)) m_er = 1;
      end
      if (st) begin m_written = 0; m_er = 0; m_ef = 0; end
    end
  end

  // per-cycle comparison against the model, plus write-address logs
  initial forever begin
    logic [31:0] ew;
    int sa, sb;
    @(negedge clk);
    if (rst_n) begin
      ew = (mq.size() > 0) ? mq[0] : 32'h0;
      sa = 1 << AWA; sb = 1 << AWB;
      chk("a_in_ready", {31'h0, ifa.in_ready}, {31'h0, (mq.size() < DEPTH) && !start});
      chk("b_in_ready", {31'h0, ifb.in_ready}, {31'h0, (mq.size() < DEPTH) && !start});
      chk("a_we", {31'h0, ifa.imem_we}, {31'h0, mq.size() > 0});
      chk("b_we", {31'h0, ifb.imem_we}, {31'h0, mq.size() > 0});
      chk("a_wdata", ifa.imem_wdata, ew);
      chk("b_wdata", ifb.imem_wdata, ew);
      chk("a_addr", ifa.imem_addr, 32'(4 * (m_written % sa)));
      chk("b_addr", ifb.imem_addr, 32'(4 * (m_written % sb)));
      chk("a_count", 32'(count_a), 32'((m_written < sa) ? m_written : sa));
      chk("b_count", 32'(count_b), 32'((m_written < sb) ? m_written : sb));
      chk("a_busy", {31'h0, busy_a}, {31'h0, mq.size() > 0});
      chk("b_busy", {31'h0, busy_b}, {31'h0, mq.size() > 0});
      chk("a_err", {30'h0, er_a, ef_a}, {30'h0, m_er, m_ef});
      chk("b_err", {30'h0, er_b, ef_b}, {30'h0, m_er, m_ef});
      if (ifa.imem_we && imem_ready) loga.push_back(ifa.imem_addr);
      if (ifb.imem_we && imem_ready) logb.push_back(ifb.imem_addr);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] o, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] fn3,
                      input logic [6:0] fn7, input logic [31:0] im);
    bit ok;
    int n;
    fmt = f; op = o; rd = d; rs1 = s1; rs2 = s2; f3 = fn3; f7 = fn7; imm = im;
    in_valid = 1'b1; ok = 0; n = 0;
    while (!ok && n < 50) begin
      @(negedge clk); ok = ifa.in_ready; tick(); n++;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'h0, 32'h1);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    // model pins
    chk("model_I", m_enc(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF), 32'hFFF0_0093);
    chk("model_B", m_enc(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC), 32'hFE20_8EE3);
    chk("model_R", m_enc(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0), 32'h4020_81B3);
    chk("immgen_B", imm_gen(32'hFE20_8EE3), 32'hFFFF_FFFC);
    chk("model_bad_J3", {31'h0, m_bad(3'd5, 32'd3)}, 32'h1);
    chk("model_ok_I", {31'h0, m_bad(3'd1, 32'hFFFF_F800)}, 32'h0);

    tick(3); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_we", {31'h0, ifa.imem_we}, 32'h0);
    chk("rst_addr", ifa.imem_addr, 32'h0);
    chk("rst_wdata", ifa.imem_wdata, 32'h0);
    chk("rst_count", 32'(count_a), 32'h0);
    chk("rst_in_ready", {31'h0, ifa.in_ready}, 32'h1);
    tick();

    // single I word
    imem_ready = 1'b1;
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("I_wdata", ifa.imem_wdata, 32'hFFF0_0093);
    chk("I_addr", ifa.imem_addr, 32'h0);
    chk("I_we", {31'h0, ifa.imem_we}, 32'h1);
    chk("I_err", {31'h0, er_a}, 32'h0);
    chk("I_roundtrip", imm_gen(ifa.imem_wdata), 32'hFFFF_FFFF);
    tick();

    // B round trip
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("B_wdata", ifa.imem_wdata, 32'hFE20_8EE3);
    chk("B_roundtrip", imm_gen(ifa.imem_wdata), 32'hFFFF_FFFC);
    tick();

    // R ignores immediate, U and back-to-back words
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    send(3'd2, 7'h23, 5'd0, 5'd2, 5'd7, 3'd2, 7'd0, 32'hFFFF_F800);
    tick(2);
    chk("RUS_err", {30'h0, er_a, ef_a}, 32'h0);

    // J range violation
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    @(negedge clk);
    chk("J_wdata", ifa.imem_wdata, 32'h0020_00EF);
    chk("J_err_range", {31'h0, er_a}, 32'h1);
    tick(3);
    chk("J_err_held", {31'h0, er_a}, 32'h1);

    // illegal format
    send(3'd7, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'h0);
    @(negedge clk);
    chk("fmt_wdata", ifa.imem_wdata, 32'h0000_0013);
    chk("fmt_err", {31'h0, ef_a}, 32'h1);
    tick(2);

    // start in IDLE clears flags and pointer
    pulse_start();
    @(negedge clk);
    chk("start_flags", {30'h0, er_a, ef_a}, 32'h0);
    chk("start_count", 32'(count_a), 32'h0);
    chk("start_addr", ifa.imem_addr, 32'h0);
    tick();

    // backpressure: four fill the FIFO, fifth waits
    loga.delete(); logb.delete();
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(3'd1, 7'h13, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i * 3));
    fmt = 3'd1; op = 7'h13; rd = 5'd9; imm = 32'd100; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_in_ready", {31'h0, ifa.in_ready}, 32'h0);
      tick();
    end
    imem_ready = 1'b1;
    send(3'd1, 7'h13, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'd100);
    tick(8);
    chk("bp_nwrites", 32'(loga.size()), 32'd5);
    for (int i = 0; i < 5 && i < loga.size(); i++)
      chk("bp_addr_a", loga[i], 32'(4 * i));
    chk("bp_count_a", 32'(count_a), 32'd5);
    chk("bp_count_b", 32'(count_b), 32'd4);

    // wrap and saturation on the small window
    pulse_start();
    loga.delete(); logb.delete();
    for (int i = 0; i < 6; i++)
      send(3'd4, 7'h17, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i) << 12);
    tick(4);
    chk("wrap_nwrites", 32'(logb.size()), 32'd6);
    begin
      logic [31:0] exp_b [6];
      exp_b = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0, 32'h4};
      for (int i = 0; i < 6 && i < logb.size(); i++) chk("wrap_addr_b", logb[i], exp_b[i]);
    end
    chk("wrap_count_b", 32'(count_b), 32'd4);
    chk("wrap_count_a", 32'(count_a), 32'd6);

    // start while RUN is ignored
    imem_ready = 1'b0;
    send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    pulse_start();
    @(negedge clk);
    chk("runstart_busy", {31'h0, busy_a}, 32'h1);
    chk("runstart_count", 32'(count_a), 32'd6);
    tick();
    imem_ready = 1'b1;
    tick(3);
    chk("runstart_drain", 32'(count_a), 32'd7);

    // reset mid-run
    pulse_start();
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(3'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_we_a", {31'h0, ifa.imem_we}, 32'h0);
    chk("rst_mid_we_b", {31'h0, ifb.imem_we}, 32'h0);
    tick(2);
    #2 rst_n = 1'b1;
    imem_ready = 1'b1;
    loga.delete(); logb.delete();
    tick(5);
    @(negedge clk);
    chk("post_rst_writes", 32'(loga.size() + logb.size()), 32'h0);
    chk("post_rst_addr", ifa.imem_addr, 32'h0);
    chk("post_rst_count", 32'(count_a), 32'h0);
    chk("post_rst_busy", {31'h0, busy_a}, 32'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the core's immediate generator. It takes RV32I instruction fields plus a decoded 32-bit immediate value and packs the immediate bits back into the R/I/S/B/U/J instruction layouts.
- Encoded words are buffered in a small FIFO, then streamed into instruction memory at sequential addresses.
- Used by the test/boot loader to build programs for the pipeline core. It also checks that each immediate survives a round trip through the decoder.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, ≥2).
- IMEM_AW, 10, instruction-memory word-address width; the write window is 2^IMEM_AW words.
- BASE_ADDR, 32'h0000_0000, byte address of the first write (word aligned).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  restart load: pointer to BASE_ADDR, count and error flags cleared.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal.
- in_opcode  in  7  opcode field.
- in_rd, in_rs1, in_rs2  in  5 each  register fields.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field (R only).
- in_imm  in  32  decoded immediate value.
- imem_we  out  1  write request.
- imem_addr  out  32  byte address.
- imem_wdata  out  32  encoded instruction.
- imem_ready  in  1  memory accepts write this cycle.
- count  out  IMEM_AW+1  words written since start/reset; saturates at 2^IMEM_AW.
- busy  out  1  FIFO non-empty.
- err_range  out  1  sticky: immediate not representable.
- err_fmt  out  1  sticky: illegal in_fmt.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, busy=0, err_range=0, err_fmt=0, FIFO empty, state IDLE.
- in_ready = !full && !start. It is 1 whenever the FIFO is not full, including out of reset.
- Encoding, computed combinationally and written into the FIFO on accept:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Range rules:
  - I/S: imm == sext(imm[11:0]).
  - B: imm[0]==0 and imm == sext(imm[12:0]).
  - J: imm[0]==0 and imm == sext(imm[20:0]).
  - U: imm[11:0]==0.
  - R: immediate ignored.
  - Violation: word is still written with the truncated bits, and err_range is set the cycle after accept.
- Illegal in_fmt: word is forced to 32'h0000_0013 (NOP), and err_fmt is set.
- Round-trip property: for legal inputs with a matching opcode, decoding imem_wdata through the team's immediate generator yields in_imm.
- Latency: a word accepted at edge N appears on imem_wdata with imem_we=1 after edge N (FIFO head drives outputs). Minimum 1 cycle; throughput 1 word/cycle when imem_ready=1.
- Write handshake:
  - imem_we = !empty.
  - A write completes when imem_we && imem_ready. Then the FIFO pops, imem_addr += 4, and count increments (saturating).
  - imem_wdata and imem_addr stay stable while imem_we && !imem_ready.
- Address wrap: after the write at BASE_ADDR + 4*(2^IMEM_AW − 1), imem_addr returns to BASE_ADDR.
- Simultaneous push and pop: both occur and occupancy is unchanged. A push when full is impossible because in_ready=0.
- FSM:
  - IDLE (empty) → RUN on accept.
  - RUN → IDLE when the last entry pops with no push in the same cycle.
  - busy = (state == RUN).
- start: honoured only in IDLE. It resets imem_addr, count, err_range and err_fmt next edge, and blocks accept that cycle. start in RUN is ignored.
- Reset mid-operation: FIFO is discarded, and imem_we drops immediately (asynchronous). No stale writes after release.

Test Plan:
- Single I word: fmt=I, opcode=7'h13, rd=1, rs1=0, f3=0, imm=32'hFFFF_FFFF → imem_wdata=32'hFFF0_0093 at addr 0x0 the cycle after accept; err_range=0.
- B round trip: fmt=B, opcode=7'h63, rs1=1, rs2=2, f3=0, imm=−4 → 32'hFE20_8EE3. Feeding this through the immediate generator returns 32'hFFFF_FFFC.
- Errors: J with imm=3 → word written with imm[0] dropped, err_range=1 and held. fmt=7 → wdata=32'h0000_0013, err_fmt=1. start in IDLE → both flags clear.
- Backpressure: imem_ready=0, offer 5 requests → 4 accepted, in_ready=0 while full. Then imem_ready=1 → writes at 0x0, 0x4, 0x8, 0xC, 0x10 in order; count=5.
- Wrap and saturation: IMEM_AW=2, 6 words → addresses 0, 4, 8, C, 0, 4; count stays at 4.
- Reset mid-run: 3 words queued, imem_ready=0, pulse rst_n low → imem_we=0 immediately. After release: addr=BASE_ADDR, count=0, busy=0, no writes issued.
